// File: rtl/cmd_pkg.sv
// ============================================================================
// Module   : cmd_pkg
// Purpose  : Definitions shared between the command-frame receiver and the
//            downstream command hub. It holds the opcode byte values, the
//            default frame length and the receiver state encoding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cmd_pkg;

    // One opcode byte followed by eight payload bytes.
    localparam int CMD_FRAME_BYTES = 9;

    localparam logic [7:0] OP_START       = 8'h01;
    localparam logic [7:0] OP_STOP        = 8'h02;
    localparam logic [7:0] OP_SET_RATE    = 8'h03;
    localparam logic [7:0] OP_SET_CFG     = 8'h04;
    localparam logic [7:0] OP_CLR_CNT     = 8'h05;
    localparam logic [7:0] OP_RD_STATUS   = 8'h06;
    localparam logic [7:0] OP_RD_CNT      = 8'h07;
    localparam logic [7:0] OP_RD_CFG      = 8'h09;
    localparam logic [7:0] OP_RD_VER      = 8'h0A;
    localparam logic [7:0] OP_RD_TRIG_CFG = 8'h0B;

    // Receiver state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PAYLOAD = 2'd1;
    localparam state_t ST_ISSUE   = 2'd2;

    // 0x08 is intentionally absent: it is a reserved code.
    function automatic logic is_supported_op(input logic [7:0] b);
        case (b)
            OP_START, OP_STOP, OP_SET_RATE, OP_SET_CFG, OP_CLR_CNT,
            OP_RD_STATUS, OP_RD_CNT, OP_RD_CFG, OP_RD_VER,
            OP_RD_TRIG_CFG: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_frame_rx_if.sv
// ============================================================================
// Module   : cmd_frame_rx_if
// Purpose  : Bundle between the UART receive FIFO, the frame receiver and the
//            command consumer.
//   rx_data / rx_data_present / rx_read : FIFO head byte, non-empty, pop
//   cmd_valid / cmd_ready               : command handshake
//   cmd_opcode / cmd_payload            : decoded command
//   err_opcode / err_timeout / busy     : status
//   modport master : the receiver (drives rx_read and the command side)
//   modport slave  : the environment (FIFO and consumer)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cmd_frame_rx_if;
    logic [7:0]  rx_data;
    logic        rx_data_present;
    logic        rx_read;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [63:0] cmd_payload;
    logic        err_opcode;
    logic        err_timeout;
    logic        busy;

    modport master (
        input  rx_data, rx_data_present, cmd_ready,
        output rx_read, cmd_valid, cmd_opcode, cmd_payload,
               err_opcode, err_timeout, busy
    );

    modport slave (
        output rx_data, rx_data_present, cmd_ready,
        input  rx_read, cmd_valid, cmd_opcode, cmd_payload,
               err_opcode, err_timeout, busy
    );
endinterface

`default_nettype wire

// File: rtl/cmd_byte_timer.sv
// ============================================================================
// Module   : cmd_byte_timer
// Purpose  : Inter-byte idle counter. It counts enabled cycles since the last
//            clear and flags the cycle that completes TIMEOUT_CYCLES idle
//            clocks.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart the count (a pop happened, or outside PAYLOAD)
//   enable      : count this cycle
//   expired     : this cycle is the TIMEOUT_CYCLES-th idle cycle
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_byte_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int          C_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(TIMEOUT_CYCLES - 1);

    logic [C_W-1:0] count_q, count_d;

    // Clear has priority, so a pop in the expiring cycle cancels the abort.
    assign expired = enable && !clear && (count_q == C_LAST);

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && (count_q != C_LAST))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule

`default_nettype wire

// File: rtl/cmd_frame_rx.sv
// ============================================================================
// Module   : cmd_frame_rx
// Purpose  : Assembles opcode + 8 payload bytes popped from a UART FIFO into
//            a command and holds it until the consumer accepts it.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cmd_frame_rx_if.master (FIFO pop side, command side, status)
// Build option : define CMD_TIMEOUT_EN to abort partial frames after
//                TIMEOUT_CYCLES idle clocks between payload bytes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_frame_rx
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FRAME_BYTES    = CMD_FRAME_BYTES
) (
    input  wire logic      clk,
    input  wire logic      reset,
    cmd_frame_rx_if.master bus
);
    // The payload port is fixed at 64 bits, so only a 9-byte frame fits.
    if (FRAME_BYTES != 9) begin : g_bad_frame_bytes
        $error("cmd_frame_rx: FRAME_BYTES must be 9");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cmd_frame_rx: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [2:0] C_LAST_IDX = 3'(FRAME_BYTES - 2);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [63:0] payload_q, payload_d;
    logic        err_opcode_q, err_opcode_d;
    logic        err_timeout_q, err_timeout_d;
    logic        pop;
    logic        timeout_hit;

    // Pop whenever data is available outside ISSUE; reset suppresses it.
    assign pop = bus.rx_data_present && (state_q != ST_ISSUE) && !reset;

`ifdef CMD_TIMEOUT_EN
    cmd_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (pop || (state_q != ST_PAYLOAD)),
        .enable  (state_q == ST_PAYLOAD),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        opcode_d      = opcode_q;
        payload_d     = payload_q;
        err_opcode_d  = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (is_supported_op(bus.rx_data)) begin
                        opcode_d  = bus.rx_data;
                        cnt_d     = 3'd0;
                        payload_d = '0;
                        state_d   = ST_PAYLOAD;
                    end else begin
                        err_opcode_d = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (pop) begin
                    payload_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    if (cnt_q == C_LAST_IDX)
                        state_d = ST_ISSUE;
                    else
                        cnt_d = cnt_q + 3'd1;
                end else if (timeout_hit) begin
                    state_d       = ST_IDLE;
                    cnt_d         = 3'd0;
                    err_timeout_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            opcode_q      <= 8'h00;
            payload_q     <= '0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            opcode_q      <= opcode_d;
            payload_q     <= payload_d;
            err_opcode_q  <= err_opcode_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.rx_read     = pop;
    assign bus.cmd_valid   = (state_q == ST_ISSUE);
    assign bus.cmd_opcode  = opcode_q;
    assign bus.cmd_payload = payload_q;
    assign bus.err_opcode  = err_opcode_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.busy        = (state_q != ST_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_rx.sv
// ============================================================================
// Module   : tb_cmd_frame_rx
// Purpose  : Self-checking bench for cmd_frame_rx. A queue models the UART
//            FIFO; every complete frame pushed also pushes its expected
//            command to a scoreboard that is checked on each valid cycle and
//            popped on handshake. Expected error pulses are counted likewise.
// Build option : CMD_TIMEOUT_EN selects the timeout abort scenario.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmd_frame_rx;
    import cmd_pkg::*;

    typedef struct packed {
        logic [7:0]  op;
        logic [63:0] pl;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmd_frame_rx_if bus ();

    cmd_frame_rx #(
        .TIMEOUT_CYCLES (50),
        .FRAME_BYTES    (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cmd_t       exp_q[$];
    logic [7:0] fifo[$];
    int exp_err_op  = 0;
    int exp_err_to  = 0;
    int checks      = 0;
    int errors      = 0;
    int valid_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.rx_data_present = (fifo.size() != 0);
        bus.rx_data         = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    task automatic push_bad(input logic [7:0] b);
        push_byte(b);
        exp_err_op++;
    endtask

    task automatic push_frame(input logic [7:0] op, input logic [63:0] pl);
        cmd_t c;
        push_byte(op);
        for (int k = 0; k < 8; k++) push_byte(pl[8*k +: 8]);
        c.op = op;
        c.pl = pl;
        exp_q.push_back(c);
    endtask

    // One clock: observe at the falling edge, update the FIFO model after
    // the rising edge.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = bus.rx_read;
        if (bus.cmd_valid) begin
            valid_cycles++;
            chk("rx_read_in_issue", bus.rx_read, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 1'b1, 1'b0);
            end else begin
                chk("cmd_opcode", bus.cmd_opcode, exp_q[0].op);
                chk("cmd_payload", bus.cmd_payload, exp_q[0].pl);
                if (bus.cmd_ready) void'(exp_q.pop_front());
            end
        end
        if (bus.err_opcode) begin
            chk("err_opcode_expected", exp_err_op > 0, 1'b1);
            if (exp_err_op > 0) exp_err_op--;
        end
        if (bus.err_timeout) begin
            chk("err_timeout_expected", exp_err_to > 0, 1'b1);
            if (exp_err_to > 0) exp_err_to--;
        end
        @(posedge clk);
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        drive_fifo();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk({tag, "_drained"}, n < budget, 1'b1);
    endtask

    task automatic drain_fifo(input string tag, input int budget);
        int n = 0;
        while (fifo.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_fifo_empty"}, n < budget, 1'b1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rx_read"},     bus.rx_read, 1'b0);
        chk({tag, "_cmd_valid"},   bus.cmd_valid, 1'b0);
        chk({tag, "_cmd_opcode"},  bus.cmd_opcode, 8'h00);
        chk({tag, "_cmd_payload"}, bus.cmd_payload, 64'h0);
        chk({tag, "_err_opcode"},  bus.err_opcode, 1'b0);
        chk({tag, "_err_timeout"}, bus.err_timeout, 1'b0);
        chk({tag, "_busy"},        bus.busy, 1'b0);
    endtask

    initial begin
        logic [7:0] ops[10];
        int n;
        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B};

        // Reset state, with a byte waiting in the FIFO to show no pop occurs.
        reset = 1'b1;
        bus.cmd_ready = 1'b0;
        drive_fifo();
        push_byte(8'h01);
        repeat (3) tick();
        chk_reset_values("reset");
        chk("reset_fifo_untouched", fifo.size(), 1);
        void'(fifo.pop_front());
        drive_fifo();
        reset = 1'b0;
        bus.cmd_ready = 1'b1;
        tick();

        // Single frame with ready high: exactly one valid cycle.
        valid_cycles = 0;
        push_frame(8'h03, 64'h0000_0000_0000_0055);
        run_until_idle("frame03", 100);
        chk("frame03_valid_cycles", valid_cycles, 1);

        // Byte ordering: first payload byte lands in [7:0].
        push_frame(8'h0A, 64'h0807_0605_0403_0201);
        run_until_idle("order", 100);

        // Unsupported opcode then a normal frame; also boundary bytes.
        push_bad(8'h08);
        push_frame(8'h02, 64'h0);
        run_until_idle("bad08", 100);
        chk("bad08_pulses", exp_err_op, 0);
        push_bad(8'h00);
        push_bad(8'h0C);
        push_bad(8'hFF);
        push_frame(8'h09, 64'hFFEE_DDCC_BBAA_9988);
        run_until_idle("bad_edges", 100);
        chk("bad_edges_pulses", exp_err_op, 0);

        // Every supported opcode carries eight payload bytes.
        for (int i = 0; i < 10; i++)
            push_frame(ops[i], {$urandom(), $urandom()});
        run_until_idle("all_ops", 400);

        // Consumer stalls 20 cycles with another frame queued behind.
        bus.cmd_ready = 1'b0;
        push_frame(8'h0B, 64'h0);
        push_frame(8'h01, 64'h1);
        n = 0;
        while (!bus.cmd_valid && n < 50) begin
            tick();
            n++;
        end
        chk("stall_valid_seen", n < 50, 1'b1);
        valid_cycles = 0;
        repeat (20) tick();
        chk("stall_valid_cycles", valid_cycles, 20);
        chk("stall_fifo_held", fifo.size(), 9);
        bus.cmd_ready = 1'b1;
        tick();
        chk("stall_handshake_valid", bus.cmd_valid, 1'b0);
        chk("stall_handshake_busy", bus.busy, 1'b0);
        run_until_idle("stall_next", 100);

        // Two frames back-to-back in the FIFO.
        push_frame(8'h03, 64'h0000_0000_0000_00AA);
        push_frame(8'h0B, 64'h0);
        run_until_idle("b2b", 100);

        // Reset after five bytes of a frame drops it silently.
        push_byte(8'h03);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        drain_fifo("midreset", 50);
        tick();
        chk("midreset_busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        chk_reset_values("midreset");
        reset = 1'b0;
        repeat (3) tick();
        push_frame(8'h03, 64'h1122_3344_5566_7788);
        run_until_idle("after_reset", 100);

`ifdef CMD_TIMEOUT_EN
        // Partial frame aborted after 50 idle cycles, then a normal frame.
        push_byte(8'h04);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        exp_err_to = 1;
        valid_cycles = 0;
        drain_fifo("timeout", 50);
        repeat (60) tick();
        chk("timeout_pulse", exp_err_to, 0);
        chk("timeout_no_cmd", valid_cycles, 0);
        chk("timeout_idle", bus.busy, 1'b0);
        push_frame(8'h01, 64'h0);
        run_until_idle("after_timeout", 100);
`else
        // Without the timeout option a partial frame waits indefinitely.
        push_byte(8'h04);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        drain_fifo("wait", 50);
        repeat (200) tick();
        chk("wait_still_busy", bus.busy, 1'b1);
        chk("wait_err_timeout", bus.err_timeout, 1'b0);
        push_byte(8'h44);
        push_byte(8'h55);
        push_byte(8'h66);
        push_byte(8'h77);
        push_byte(8'h88);
        exp_q.push_back('{op: 8'h04, pl: 64'h8877_6655_4433_2211});
        run_until_idle("wait_complete", 100);
`endif

        chk("final_scoreboard_empty", exp_q.size(), 0);
        chk("final_err_opcode_pending", exp_err_op, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning max idle clocks between payload bytes before frame abort.
REQ-002 SHALL have parameter FRAME_BYTES, default 9, meaning bytes per command frame (1 opcode + 8 payload).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset: synchronous, active-high.
REQ-005 SHALL have port rx_data, input, 8, meaning head byte of uart_rx6 FIFO (data_out).
REQ-006 SHALL have port rx_data_present, input, 1, meaning FIFO non-empty.
REQ-007 SHALL have port rx_read, output, 1, meaning one-cycle FIFO pop (buffer_read).
REQ-008 SHALL have port cmd_valid, output, 1, meaning complete command held for consumer.
REQ-009 SHALL have port cmd_ready, input, 1, meaning consumer accepts command.
REQ-010 SHALL have port cmd_opcode, output, 8, meaning decoded opcode.
REQ-011 SHALL have port cmd_payload, output, 64, meaning payload, first received payload byte in [7:0].
REQ-012 SHALL have port err_opcode, output, 1, meaning one-cycle pulse on unsupported opcode byte.
REQ-013 SHALL have port err_timeout, output, 1, meaning one-cycle pulse on aborted partial frame.
REQ-014 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, PAYLOAD, ISSUE.
REQ-016 SHALL assert rx_read = rx_data_present in IDLE and PAYLOAD, and 0 in ISSUE; rx_data is sampled in the cycle rx_read is high; back-to-back pops every cycle are supported.
REQ-017 IDLE: popped byte in {01,02,03,04,05,06,07,09,0A,0B} SHALL be latched to cmd_opcode, clear the byte count, clear cmd_payload, and go to PAYLOAD.
REQ-018 IDLE: any other popped byte SHALL be discarded with err_opcode pulsed the next cycle, and the state SHALL remain IDLE.
REQ-019 PAYLOAD: the k-th popped byte (k=0..7) SHALL be written to cmd_payload[8k+7:8k]; the 8th byte SHALL move the state to ISSUE.
REQ-020 cmd_valid SHALL assert the cycle after the final payload byte is popped (9th pop overall) and hold with stable opcode/payload until cmd_valid & cmd_ready.
REQ-021 On handshake the next state SHALL be IDLE with cmd_valid low; the next pop occurs no earlier than that IDLE cycle.
REQ-022 The byte counter SHALL be 3 bits with no wrap; count 7 is terminal.
REQ-023 cmd_ready while cmd_valid is low SHALL be ignored.
REQ-024 All opcodes, including payload-free ones (01,02,05,06,07,09,0A,0B), SHALL carry exactly 8 payload bytes.

Reset
REQ-025 With reset high at a clock edge: state=IDLE, rx_read=0, cmd_valid=0, cmd_opcode=0x00, cmd_payload=0, err_opcode=0, err_timeout=0, busy=0, counters=0.
REQ-026 Reset mid-frame or during ISSUE SHALL drop the frame silently (no error pulse); bytes remaining in the FIFO are then parsed as new frames.

Configuration
REQ-027 Macro CMD_TIMEOUT_EN defined: an inter-byte counter SHALL clear on every pop and on entry to PAYLOAD; in PAYLOAD, reaching TIMEOUT_CYCLES clocks with no pop SHALL discard the frame, pulse err_timeout, and return to IDLE; the counter SHALL be inactive in IDLE and ISSUE.
REQ-028 Macro CMD_TIMEOUT_EN undefined: no counter logic SHALL exist, err_timeout SHALL be tied 0, and PAYLOAD SHALL wait indefinitely.
REQ-029 If a pop and the timeout occur in the same cycle, the pop SHALL win (no abort).

Structure
REQ-030 Package cmd_pkg SHALL hold the opcode constants (OP_START=01 ... OP_RD_TRIG_CFG=0B), the FRAME_BYTES default, and the state enumeration; it is shared with the downstream command hub.
REQ-031 The timeout counter SHALL be a sub-module, cmd_byte_timer, instantiated only under CMD_TIMEOUT_EN.

Verification
REQ-032 Bytes 03,55,00x7 with cmd_ready=1 -> cmd_valid for 1 cycle, opcode 0x03, payload 0x0000000000000055.
REQ-033 Frame 0B,00x8 with cmd_ready=0 for 20 cycles -> cmd_valid high and stable 20 cycles, rx_read=0 throughout, handshake on cycle 21, then IDLE.
REQ-034 Byte 08 then frame 02,00x8 -> err_opcode pulse once, then opcode 0x02 command issued normally.
REQ-035 (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=50) Bytes 04,11,22,33 then 50 idle cycles -> err_timeout pulse, no cmd_valid; a following frame 01,00x8 is issued correctly.
REQ-036 Reset asserted after 5 bytes of frame 03 -> outputs at reset values, no error pulse; the next full frame parses correctly.
REQ-037 Two frames back-to-back in the FIFO (03,AA,00x7 then 0B,00x8) -> two commands in order with correct payloads, none lost.
